// File: rtl/alarm_ctrl.sv
// alarm_ctrl: zone synchroniser and mask, arm/exit/entry/siren sequencing FSM,
// sticky record of tripped zones and a saturating alarm event counter.
module alarm_ctrl #(
  parameter int unsigned EXIT_CYCLES  = 16,
  parameter int unsigned ENTRY_CYCLES = 16,
  parameter int unsigned SIREN_CYCLES = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] zone,
  input  logic [3:0] zone_mask,
  input  logic       arm,
  input  logic       disarm,
  output logic       siren,
  output logic       armed,
  output logic       beep,
  output logic [2:0] state,
  output logic [3:0] zone_mem,
  output logic [7:0] alarm_cnt
);

  localparam int unsigned ZONE_W = 4;
  localparam int unsigned EVT_W  = 8;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ZONE_W-1:0]  zone_s1, zone_s2;
  logic [ZONE_W-1:0]  hit, mem_d;
  logic [EVT_W-1:0]   alarm_cnt_d;
  logic               trip;
  logic               siren_d, armed_d, beep_d;

  assign hit   = zone_s2 & zone_mask;
  assign trip  = |hit;
  assign state = state_q;

  // Two-flop synchroniser for the asynchronous zone lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zone_s1 <= '0;
      zone_s2 <= '0;
    end else begin
      zone_s1 <= zone;
      zone_s2 <= zone_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_DISARMED;
      cnt_q     <= '0;
      zone_mem  <= '0;
      alarm_cnt <= '0;
      siren     <= 1'b0;
      armed     <= 1'b0;
      beep      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      zone_mem  <= mem_d;
      alarm_cnt <= alarm_cnt_d;
      siren     <= siren_d;
      armed     <= armed_d;
      beep      <= beep_d;
    end
  end

  // Next state; output flops load the decode of the next state so they track state_q
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_d       = zone_mem;
    alarm_cnt_d = alarm_cnt;

    if (state_q inside {S_ARMED, S_ENTRY, S_ALARM, S_HOLD}) begin
      mem_d = zone_mem | hit;
    end

    if (disarm) begin
      state_d = S_DISARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (arm) begin
            state_d = S_EXIT;
            cnt_d   = CNT_W'(EXIT_CYCLES - 1);
            mem_d   = '0;
          end
        end
        S_EXIT: begin
          if (cnt_q == '0) state_d = S_ARMED;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_ARMED: begin
          if (trip) begin
            state_d = S_ENTRY;
            cnt_d   = CNT_W'(ENTRY_CYCLES - 1);
          end
        end
        S_ENTRY: begin
          if (cnt_q == '0) begin
            state_d = S_ALARM;
            cnt_d   = CNT_W'(SIREN_CYCLES - 1);
            if (alarm_cnt != '1) alarm_cnt_d = alarm_cnt + EVT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_ALARM: begin
          if (cnt_q == '0) state_d = S_HOLD;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_HOLD: begin
          if (trip) begin
            state_d = S_ALARM;
            cnt_d   = CNT_W'(SIREN_CYCLES - 1);
          end
        end
        default: begin
          state_d = S_DISARMED;
          cnt_d   = '0;
        end
      endcase
    end

    siren_d = (state_d == S_ALARM);
    armed_d = state_d inside {S_ARMED, S_ENTRY, S_ALARM, S_HOLD};
    beep_d  = state_d inside {S_EXIT, S_ENTRY};
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed vector table, corner-case sequences
// and randomized traffic against a cycles-remaining reference model.
module tb_alarm_ctrl;
  localparam int unsigned EXIT_C  = 4;
  localparam int unsigned ENTRY_C = 3;
  localparam int unsigned SIREN_C = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] zone = '0;
  logic [3:0] zone_mask = '0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       siren, armed, beep;
  logic [2:0] state;
  logic [3:0] zone_mem;
  logic [7:0] alarm_cnt;

  alarm_ctrl #(
    .EXIT_CYCLES (EXIT_C),
    .ENTRY_CYCLES(ENTRY_C),
    .SIREN_CYCLES(SIREN_C),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .zone     (zone),
    .zone_mask(zone_mask),
    .arm      (arm),
    .disarm   (disarm),
    .siren    (siren),
    .armed    (armed),
    .beep     (beep),
    .state    (state),
    .zone_mem (zone_mem),
    .alarm_cnt(alarm_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase number plus cycles left in the current timed phase
  int         m_phase;
  int         m_left;
  int         m_cnt;
  logic [3:0] m_s1, m_s2, m_mem;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_cnt = 0;
    m_s1 = '0; m_s2 = '0; m_mem = '0;
  endtask

  task automatic model_step(input logic [3:0] z, input logic [3:0] m,
                            input logic a, input logic d);
    logic [3:0] hit;
    hit = m_s2 & m;
    if (m_phase >= 2 && m_phase <= 5) m_mem = m_mem | hit;
    m_s2 = m_s1;
    m_s1 = z;
    if (d) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (a) begin m_phase = 1; m_left = EXIT_C; m_mem = '0; end
        1: if (m_left == 1) m_phase = 2; else m_left--;
        2: if (hit != 0) begin m_phase = 3; m_left = ENTRY_C; end
        3: if (m_left == 1) begin
             m_phase = 4; m_left = SIREN_C;
             if (m_cnt < 255) m_cnt++;
           end else m_left--;
        4: if (m_left == 1) m_phase = 5; else m_left--;
        5: if (hit != 0) begin m_phase = 4; m_left = SIREN_C; end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".state"},     int'(state),     m_phase);
    chk({tag, ".siren"},     int'(siren),     int'(m_phase == 4));
    chk({tag, ".armed"},     int'(armed),     int'(m_phase >= 2 && m_phase <= 5));
    chk({tag, ".beep"},      int'(beep),      int'(m_phase == 1 || m_phase == 3));
    chk({tag, ".zone_mem"},  int'(zone_mem),  int'(m_mem));
    chk({tag, ".alarm_cnt"}, int'(alarm_cnt), m_cnt);
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later
  task automatic step(input string tag, input logic [3:0] z, input logic [3:0] m,
                      input logic a, input logic d);
    zone = z; zone_mask = m; arm = a; disarm = d;
    @(posedge clk);
    model_step(z, m, a, d);
    #1;
    compare_model(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic [3:0] z);
    for (int i = 0; i < n; i++) step(tag, z, 4'hF, 1'b0, 1'b0);
  endtask

  // Idle with given zone until state reaches target or budget runs out
  task automatic run_to(input string tag, input int target, input int budget,
                        input logic [3:0] z);
    for (int i = 0; i < budget && int'(state) != target; i++)
      step(tag, z, 4'hF, 1'b0, 1'b0);
    chk({tag, ".reach"}, int'(state), target);
  endtask

  typedef struct {
    logic [3:0] z;
    logic [3:0] m;
    logic       a;
    logic       d;
    logic [2:0] st;
    logic       sir;
    logic       arm_o;
    logic       bp;
    logic [3:0] mem;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int         saw_siren;
    int         siren_len;
    int         cnt_before;
    logic [3:0] rz;

    //            z     m     a     d     st    sir   arm   bp    mem   cnt
    tbl[0]  = '{4'h0, 4'hF, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd0};
    tbl[1]  = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd0};
    tbl[2]  = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd0};
    tbl[3]  = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd0};
    tbl[4]  = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0};
    tbl[5]  = '{4'h2, 4'hF, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0};
    tbl[6]  = '{4'h2, 4'hF, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0};
    tbl[7]  = '{4'h2, 4'hF, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 4'h2, 8'd0};
    tbl[8]  = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 4'h2, 8'd0};
    tbl[9]  = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 4'h2, 8'd0};
    tbl[10] = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 4'h2, 8'd1};
    tbl[11] = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 4'h2, 8'd1};
    tbl[12] = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 4'h2, 8'd1};
    tbl[13] = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 4'h2, 8'd1};
    tbl[14] = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 4'h2, 8'd1};
    tbl[15] = '{4'h0, 4'hF, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 4'h2, 8'd1};
    tbl[16] = '{4'h0, 4'hF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'h2, 8'd1};
    tbl[17] = '{4'h0, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'h2, 8'd1};

    model_reset();
    #12;
    chk("rst.state", int'(state), 0);
    chk("rst.outs",  int'({siren, armed, beep}), 0);
    chk("rst.mem",   int'(zone_mem), 0);
    chk("rst.cnt",   int'(alarm_cnt), 0);
    rst = 1'b0;

    // Directed vector table: exit delay, trip through entry/alarm/hold, disarm
    for (int i = 0; i < 18; i++) begin
      step("tbl", tbl[i].z, tbl[i].m, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d.state", i), int'(state),     int'(tbl[i].st));
      chk($sformatf("tbl%0d.siren", i), int'(siren),     int'(tbl[i].sir));
      chk($sformatf("tbl%0d.armed", i), int'(armed),     int'(tbl[i].arm_o));
      chk($sformatf("tbl%0d.beep", i),  int'(beep),      int'(tbl[i].bp));
      chk($sformatf("tbl%0d.mem", i),   int'(zone_mem),  int'(tbl[i].mem));
      chk($sformatf("tbl%0d.cnt", i),   int'(alarm_cnt), int'(tbl[i].cnt));
    end

    // Masked-out zone does not trip and is not recorded
    step("mask", 4'h0, 4'h7, 1'b1, 1'b0);
    run_to("mask.exit", 2, 10, 4'h0);
    for (int i = 0; i < 6; i++) step("mask", 4'h8, 4'h7, 1'b0, 1'b0);
    chk("mask.state", int'(state), 2);
    chk("mask.mem",   int'(zone_mem), 0);
    step("mask.dis", 4'h0, 4'h7, 1'b0, 1'b1);
    chk("mask.dis_state", int'(state), 0);

    // Disarm during the second ENTRY cycle
    cnt_before = int'(alarm_cnt);
    step("ent", 4'h0, 4'hF, 1'b1, 1'b0);
    run_to("ent.exit", 2, 10, 4'h0);
    run_to("ent.trip", 3, 6, 4'h1);
    saw_siren = 0;
    step("ent.c2", 4'h1, 4'hF, 1'b0, 1'b1);
    chk("ent.dis_state", int'(state), 0);
    for (int i = 0; i < 6; i++) begin
      step("ent.flush", 4'h0, 4'hF, 1'b0, 1'b0);
      if (siren) saw_siren = 1;
    end
    chk("ent.no_siren", saw_siren, 0);
    chk("ent.cnt", int'(alarm_cnt), cnt_before);

    // HOLD re-trip returns to ALARM for full siren time without counting
    step("hold", 4'h0, 4'hF, 1'b1, 1'b0);
    run_to("hold.exit", 2, 10, 4'h0);
    step("hold.z", 4'h4, 4'hF, 1'b0, 1'b0);
    run_to("hold.hold", 5, 20, 4'h0);
    idle("hold.idle", 3, 4'h0);
    chk("hold.stay", int'(state), 5);
    cnt_before = int'(alarm_cnt);
    step("hold.z2", 4'h4, 4'hF, 1'b0, 1'b0);
    run_to("hold.realarm", 4, 5, 4'h0);
    siren_len = 0;
    for (int i = 0; i < 10 && siren; i++) begin
      siren_len++;
      step("hold.siren", 4'h0, 4'hF, 1'b0, 1'b0);
    end
    chk("hold.siren_len", siren_len, int'(SIREN_C));
    chk("hold.back", int'(state), 5);
    chk("hold.cnt", int'(alarm_cnt), cnt_before);

    // Asynchronous reset in the middle of ALARM
    step("rst", 4'h0, 4'hF, 1'b0, 1'b1);
    step("rst", 4'h0, 4'hF, 1'b1, 1'b0);
    run_to("rst.exit", 2, 10, 4'h0);
    step("rst.z", 4'h1, 4'hF, 1'b0, 1'b0);
    run_to("rst.alarm", 4, 10, 4'h0);
    step("rst.mid", 4'h0, 4'hF, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst.state", int'(state), 0);
    chk("arst.outs",  int'({siren, armed, beep}), 0);
    chk("arst.mem",   int'(zone_mem), 0);
    chk("arst.cnt",   int'(alarm_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // 256 forced alarms saturate the counter at 255
    for (int n = 0; n < 256; n++) begin
      step("sat", 4'h0, 4'hF, 1'b1, 1'b0);
      run_to("sat.exit", 2, 10, 4'h0);
      step("sat.z", 4'h1, 4'hF, 1'b0, 1'b0);
      run_to("sat.alarm", 4, 10, 4'h0);
      step("sat.dis", 4'h0, 4'hF, 1'b0, 1'b1);
    end
    chk("sat.cnt", int'(alarm_cnt), 255);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rz = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step("rnd", rz, 4'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
